// File: rtl/txregif_pkg.sv
// -----------------------------------------------------------------------------
// txregif_pkg
// Shared types and constants for the TX register-interface framer.
//   state_e      : framer FSM states (ST_CSUM exists only when TXREGIF_CSUM_EN
//                  is defined)
//   OPC_WR/OPC_RD: opcode byte that follows SOF in write / read-request frames
//   SOF_DEFAULT  : default start-of-frame header byte
// Configuration macro: TXREGIF_CSUM_EN
// -----------------------------------------------------------------------------
package txregif_pkg;

  localparam logic [7:0] OPC_WR      = 8'h01;
  localparam logic [7:0] OPC_RD      = 8'h02;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OPC,
    ST_ADDR,
    ST_DATA
`ifdef TXREGIF_CSUM_EN
    ,
    ST_CSUM
`endif
  } state_e;

endpackage

// File: rtl/txregif_csum.sv
// -----------------------------------------------------------------------------
// txregif_csum
// XOR accumulator for the optional trailing checksum byte.
//   clk, reset_ : clock, asynchronous active-low reset
//   clr         : clear the accumulator (command accepted); wins over upd
//   upd         : fold din into the accumulator (non-SOF byte written)
//   din         : byte being written to the FIFO
//   csum        : running XOR of all folded bytes
// Only instantiated when TXREGIF_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module txregif_csum
  import txregif_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  logic [7:0] csum_q;
  logic [7:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr) begin
      csum_d = 8'h00;
    end else if (upd) begin
      csum_d = csum_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/txregif_frame_tx.sv
// -----------------------------------------------------------------------------
// txregif_frame_tx
// Transmit-side framer of the AXIS register-interface bridge. Accepts one
// register command per valid/ready handshake and serializes it MSB-first into
// bytes for the bridge FIFO write port.
//   Write frame: SOF, OPC_WR, addr bytes, data bytes [, csum]
//   Read frame : SOF, OPC_RD, addr bytes [, csum]
// Ports:
//   clk, reset_          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_wr               : 1 = write frame, 0 = read-request frame
//   cmd_addr, cmd_wdata  : register address / write data (latched on accept)
//   fifo_wren            : byte write strobe (busy && !fifo_wrfull)
//   fifo_datain          : current byte, stable while the FIFO is full
//   fifo_wrfull          : FIFO full, blocks the write
//   busy                 : frame in progress
//   frame_cnt            : completed frames, wraps
// Configuration macro: TXREGIF_CSUM_EN appends an XOR checksum of every
// non-SOF byte as the last frame byte.
// -----------------------------------------------------------------------------
module txregif_frame_tx
  import txregif_pkg::*;
#(
  parameter int         ADDR_BYTES = 2,
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] SOF        = SOF_DEFAULT,
  parameter int         CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    fifo_wren,
  output logic [7:0]              fifo_datain,
  input  logic                    fifo_wrfull,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cmd_wr_q, cmd_wr_d;
  logic [8*ADDR_BYTES-1:0] cmd_addr_q, cmd_addr_d;
  logic [8*DATA_BYTES-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

  logic accept;
  logic last_byte;
  logic [7:0] csum_byte;

`ifdef TXREGIF_CSUM_EN
  logic csum_upd;

  // SOF is excluded from the checksum, and the checksum byte itself is never
  // folded back in.
  assign csum_upd = fifo_wren &&
                    ((state_q == ST_OPC) || (state_q == ST_ADDR) || (state_q == ST_DATA));

  txregif_csum u_csum (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (accept),
    .upd    (csum_upd),
    .din    (fifo_datain),
    .csum   (csum_byte)
  );
`else
  assign csum_byte = 8'h00;
`endif

  // The last byte of a frame is the one whose write lets the FSM leave the
  // frame; cmd_ready opens in that very cycle for zero-gap back-to-back frames.
  always_comb begin
`ifdef TXREGIF_CSUM_EN
    last_byte = (state_q == ST_CSUM);
`else
    last_byte = ((state_q == ST_ADDR) && (idx_q == '0) && !cmd_wr_q) ||
                ((state_q == ST_DATA) && (idx_q == '0));
`endif
  end

  assign busy      = (state_q != ST_IDLE);
  assign fifo_wren = busy && !fifo_wrfull;
  assign cmd_ready = (state_q == ST_IDLE) || (fifo_wren && last_byte);
  assign accept    = cmd_valid && cmd_ready;
  assign frame_cnt = frame_cnt_q;

  // Byte mux: purely a function of registered state, so it cannot move while
  // the FIFO is full.
  always_comb begin
    fifo_datain = 8'h00;
    unique case (state_q)
      ST_HDR:  fifo_datain = SOF;
      ST_OPC:  fifo_datain = cmd_wr_q ? OPC_WR : OPC_RD;
      ST_ADDR: fifo_datain = cmd_addr_q[8*int'(idx_q) +: 8];
      ST_DATA: fifo_datain = cmd_wdata_q[8*int'(idx_q) +: 8];
`ifdef TXREGIF_CSUM_EN
      ST_CSUM: fifo_datain = csum_byte;
`endif
      default: fifo_datain = 8'h00;
    endcase
  end

  // NOTE: every signal is given its hold value before the case statement so no
  // path through this block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    frame_cnt_d = frame_cnt_q;

    if (fifo_wren) begin
      unique case (state_q)
        ST_HDR: state_d = ST_OPC;
        ST_OPC: begin
          state_d = ST_ADDR;
          idx_d   = IDX_W'(ADDR_BYTES - 1);
        end
        ST_ADDR: begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (cmd_wr_q) begin
            state_d = ST_DATA;
            idx_d   = IDX_W'(DATA_BYTES - 1);
          end else begin
`ifdef TXREGIF_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
        ST_DATA: begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
`ifdef TXREGIF_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef TXREGIF_CSUM_EN
        ST_CSUM: state_d = ST_IDLE;
`endif
        default: state_d = state_q;
      endcase
    end

    if (fifo_wren && last_byte) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    // A command accepted on the last byte overrides the return to IDLE.
    if (accept) begin
      state_d     = ST_HDR;
      cmd_wr_d    = cmd_wr;
      cmd_addr_d  = cmd_addr;
      cmd_wdata_d = cmd_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
